// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car drive and the controller that commands it.
package elevator_pkg;

    typedef enum logic [1:0] {
        PARKED = 2'd0,
        TRAVEL = 2'd1,
        ARRIVE = 2'd2,
        FAULT  = 2'd3
    } carState_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_NUM_FLOORS = 5;

endpackage

// File: rtl/elevator_travel_timer.sv
// Sub-floor position counter: advances while enabled and wraps to zero on its terminal count.
module elevator_travel_timer #(
    parameter int TRAVEL_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam int POS_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(TRAVEL_CYCLES - 1);

    logic [POS_W-1:0] subPos_q, subPos_d;

    always_comb begin
        subPos_d = subPos_q;
        if (clear_i) begin
            subPos_d = '0;
        end else if (enable_i) begin
            subPos_d = (subPos_q == LAST_POS) ? '0 : subPos_q + POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            subPos_q <= '0;
        end else begin
            subPos_q <= subPos_d;
        end
    end

    assign terminal_o = (subPos_q == LAST_POS);

endmodule

// File: rtl/elevator_car_drive.sv
// Elevator car and shaft plant: turns dir/move commands into car motion, floor sensor pulses
// and position reporting, latching a sticky fault on over-travel or mid-shaft reversal.
module elevator_car_drive
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = DEFAULT_NUM_FLOORS,
    parameter int TRAVEL_CYCLES = 16,
    parameter int INIT_FLOOR    = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          dir,
    input  logic                          move,
    output logic [NUM_FLOORS-1:0]         floor_sensors,
    output logic [NUM_FLOORS-1:0]         floor_level,
    output logic [$clog2(NUM_FLOORS)-1:0] car_floor,
    output logic                          at_floor,
    output logic                          stalled,
    output logic                          fault
);

    localparam int FLOOR_W = $clog2(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0]    TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0]    INIT_IDX   = FLOOR_W'(INIT_FLOOR);
    localparam logic [NUM_FLOORS-1:0] ONE_HOT_0  = NUM_FLOORS'(1);

    carState_e              state_q, state_d;
    logic [FLOOR_W-1:0]     carFloor_q, carFloor_d;
    logic                   runDir_q, runDir_d;
    logic [NUM_FLOORS-1:0]  sensors_q, sensors_d;
    logic [NUM_FLOORS-1:0]  level_q, level_d;
    logic                   atFloor_q, atFloor_d;
    logic                   stalled_q, stalled_d;
    logic                   fault_q, fault_d;
    logic                   timerClear, timerEnable, timerTerminal;
    logic                   overTravel;

    elevator_travel_timer #(
        .TRAVEL_CYCLES(TRAVEL_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (timerClear),
        .enable_i  (timerEnable),
        .terminal_o(timerTerminal)
    );

    assign overTravel = ((dir == DIR_UP)   && (carFloor_q == TOP_FLOOR)) ||
                        ((dir == DIR_DOWN) && (carFloor_q == '0));

    // Sub-floor position restarts from zero whenever the car is not between floors.
    assign timerClear = (state_q != TRAVEL);

    always_comb begin
        state_d     = state_q;
        carFloor_d  = carFloor_q;
        runDir_d    = runDir_q;
        sensors_d   = '0;
        level_d     = level_q;
        atFloor_d   = atFloor_q;
        stalled_d   = 1'b0;
        timerEnable = 1'b0;

        case (state_q)
            PARKED, ARRIVE: begin
                if (!move) begin
                    state_d = PARKED;
                end else if (overTravel) begin
                    state_d = FAULT;
                end else begin
                    state_d   = TRAVEL;
                    runDir_d  = dir;
                    sensors_d = ONE_HOT_0 << carFloor_q;
                end
            end
            TRAVEL: begin
                if (!move) begin
                    stalled_d = 1'b1;
                end else if (dir != runDir_q) begin
                    state_d = FAULT;
                end else begin
                    timerEnable = 1'b1;
                    if (timerTerminal) begin
                        state_d    = ARRIVE;
                        carFloor_d = (runDir_q == DIR_UP) ? carFloor_q + FLOOR_W'(1)
                                                          : carFloor_q - FLOOR_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase

        // Alignment outputs follow the destination state; a fault freezes them as they were.
        case (state_d)
            PARKED, ARRIVE: begin
                level_d   = ONE_HOT_0 << carFloor_d;
                atFloor_d = 1'b1;
            end
            TRAVEL: begin
                level_d   = '0;
                atFloor_d = 1'b0;
            end
            default: begin
            end
        endcase

        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= PARKED;
            carFloor_q <= INIT_IDX;
            runDir_q   <= DIR_DOWN;
            sensors_q  <= '0;
            level_q    <= ONE_HOT_0 << INIT_IDX;
            atFloor_q  <= 1'b1;
            stalled_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            carFloor_q <= carFloor_d;
            runDir_q   <= runDir_d;
            sensors_q  <= sensors_d;
            level_q    <= level_d;
            atFloor_q  <= atFloor_d;
            stalled_q  <= stalled_d;
            fault_q    <= fault_d;
        end
    end

    assign floor_sensors = sensors_q;
    assign floor_level   = level_q;
    assign car_floor     = carFloor_q;
    assign at_floor      = atFloor_q;
    assign stalled       = stalled_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_elevator_car_drive.sv
// Bench for elevator_car_drive: directed scenarios plus random command streams against a
// floor/progress model of the car.
module tb_elevator_car_drive;

    localparam int NF   = 5;
    localparam int TC   = 16;
    localparam int INIT = 0;
    localparam int FW   = $clog2(NF);
    localparam int VW   = 2 * NF + FW + 3;

    logic          clk;
    logic          reset_n;
    logic          dir;
    logic          move;
    logic [NF-1:0] floor_sensors;
    logic [NF-1:0] floor_level;
    logic [FW-1:0] car_floor;
    logic          at_floor;
    logic          stalled;
    logic          fault;

    int checks   = 0;
    int failures = 0;

    // Model of the car: which floor it last touched, how far it has moved since leaving it.
    int            mFloor;
    int            mTicks;
    bit            mMoving;
    bit            mUp;
    bit            mFault;
    logic [NF-1:0] eSensors;
    logic [NF-1:0] eLevel;
    logic          eAt;
    logic          eStalled;
    logic          eFault;

    elevator_car_drive #(
        .NUM_FLOORS   (NF),
        .TRAVEL_CYCLES(TC),
        .INIT_FLOOR   (INIT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dir          (dir),
        .move         (move),
        .floor_sensors(floor_sensors),
        .floor_level  (floor_level),
        .car_floor    (car_floor),
        .at_floor     (at_floor),
        .stalled      (stalled),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NF-1:0] oneHot(input int f);
        logic [NF-1:0] v;
        v = '0;
        v[f] = 1'b1;
        return v;
    endfunction

    function automatic logic [VW-1:0] expVec();
        return {eSensors, eLevel, FW'(mFloor), eAt, eStalled, eFault};
    endfunction

    function automatic logic [VW-1:0] obsVec();
        return {floor_sensors, floor_level, car_floor, at_floor, stalled, fault};
    endfunction

    task automatic modelStep(input bit rn, input bit d, input bit m);
        if (!rn) begin
            mFloor = INIT; mTicks = 0; mMoving = 0; mUp = 0; mFault = 0;
            eSensors = '0; eLevel = oneHot(INIT); eAt = 1; eStalled = 0; eFault = 0;
            return;
        end
        eSensors = '0;
        eStalled = 0;
        if (mFault) return;
        if (!mMoving) begin
            if (m) begin
                if ((d && mFloor == NF - 1) || (!d && mFloor == 0)) begin
                    mFault = 1; eFault = 1;
                end else begin
                    mMoving = 1; mUp = d; mTicks = 0;
                    eSensors = oneHot(mFloor); eLevel = '0; eAt = 0;
                end
            end else begin
                eLevel = oneHot(mFloor); eAt = 1;
            end
        end else if (!m) begin
            eStalled = 1;
        end else if (d != mUp) begin
            mFault = 1; eFault = 1;
        end else begin
            mTicks++;
            if (mTicks == TC) begin
                mFloor = mUp ? mFloor + 1 : mFloor - 1;
                mMoving = 0;
                eLevel = oneHot(mFloor); eAt = 1;
            end
        end
    endtask

    task automatic tick(input bit rn, input bit d, input bit m);
        @(negedge clk);
        reset_n = rn; dir = d; move = m;
        @(posedge clk);
        modelStep(rn, d, m);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (obsVec() !== expVec()) begin
            failures++;
            $display("[TB] FAIL reset_model: got %h expected %h", obsVec(), expVec());
        end
        checks++;
        if (car_floor !== FW'(0) || floor_level !== NF'(1) || at_floor !== 1'b1 ||
            floor_sensors !== '0 || fault !== 1'b0 || stalled !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_values: got floor=%0d level=%b at=%b sens=%b fault=%b stall=%b expected 0 00001 1 00000 0 0",
                     car_floor, floor_level, at_floor, floor_sensors, fault, stalled);
        end
    endtask

    task automatic test_continuous_up();
        for (int c = 1; c <= 34; c++) begin
            tick(1'b1, 1'b1, 1'b1);
            checks++;
            if (obsVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL run_cycle%0d: got %h expected %h", c, obsVec(), expVec());
            end
            if (c == 1 || c == 18) begin
                checks++;
                if (floor_sensors !== ((c == 1) ? NF'(1) : NF'(2))) begin
                    failures++;
                    $display("[TB] FAIL run_sensor_c%0d: got %b expected %b", c, floor_sensors,
                             (c == 1) ? NF'(1) : NF'(2));
                end
            end
            if (c == 17 || c == 34) begin
                checks++;
                if (car_floor !== ((c == 17) ? FW'(1) : FW'(2)) || at_floor !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL run_arrive_c%0d: got floor=%0d at=%b expected floor=%0d at=1",
                             c, car_floor, at_floor, (c == 17) ? 1 : 2);
                end
            end
        end
    endtask

    task automatic test_stop_at_floor();
        tick(1'b1, 1'b1, 1'b0);
        checks++;
        if (floor_level !== NF'(4) || at_floor !== 1'b1 || car_floor !== FW'(2)) begin
            failures++;
            $display("[TB] FAIL stop_level: got level=%b at=%b floor=%0d expected 00100 1 2",
                     floor_level, at_floor, car_floor);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            checks++;
            if (floor_sensors !== '0 || obsVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL stop_idle%0d: got %h expected %h", i, obsVec(), expVec());
            end
        end
    endtask

    task automatic test_stall();
        int arrivedAt;
        arrivedAt = -1;
        for (int n = 1; n <= 8; n++) tick(1'b1, 1'b1, 1'b1);
        for (int n = 9; n <= 13; n++) begin
            tick(1'b1, 1'b1, 1'b0);
            checks++;
            if (stalled !== 1'b1 || obsVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL stall_tick%0d: got stalled=%b vec=%h expected stalled=1 vec=%h",
                         n, stalled, obsVec(), expVec());
            end
        end
        for (int n = 14; n <= 40; n++) begin
            tick(1'b1, 1'b1, 1'b1);
            if (at_floor === 1'b1) begin
                arrivedAt = n;
                break;
            end
        end
        checks++;
        if (arrivedAt != 22 || car_floor !== FW'(3) || stalled !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_arrival: got tick=%0d floor=%0d stalled=%b expected tick=22 floor=3 stalled=0",
                     arrivedAt, car_floor, stalled);
        end
        tick(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_over_travel();
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        checks++;
        if (fault !== 1'b1 || floor_sensors !== '0) begin
            failures++;
            $display("[TB] FAIL overtravel_fault: got fault=%b sens=%b expected 1 00000", fault, floor_sensors);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'(i % 2));
            checks++;
            if (fault !== 1'b1 || car_floor !== FW'(0) || obsVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL overtravel_sticky%0d: got %h expected %h", i, obsVec(), expVec());
            end
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0 || car_floor !== FW'(0) || at_floor !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overtravel_clear: got fault=%b floor=%0d at=%b expected 0 0 1",
                     fault, car_floor, at_floor);
        end
    endtask

    task automatic test_reversal_and_reset();
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        checks++;
        if (fault !== 1'b1 || at_floor !== 1'b0 || floor_level !== '0) begin
            failures++;
            $display("[TB] FAIL reversal_fault: got fault=%b at=%b level=%b expected 1 0 00000",
                     fault, at_floor, floor_level);
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (car_floor !== FW'(0) || at_floor !== 1'b1 || floor_sensors !== '0 ||
            floor_level !== NF'(1) || fault !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midtravel_reset: got %h expected %h", obsVec(), expVec());
        end
        tick(1'b1, 1'b1, 1'b0);
        checks++;
        if (floor_sensors !== '0 || obsVec() !== expVec()) begin
            failures++;
            $display("[TB] FAIL midtravel_after: got %h expected %h", obsVec(), expVec());
        end
    endtask

    task automatic test_random();
        bit rn, d, m;
        d = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            rn = mFault ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 799) != 0);
            if (!mMoving) d = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 299) == 0) d = ~d;
            m = ($urandom_range(0, 9) != 0);
            tick(rn, d, m);
            checks++;
            if (obsVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, obsVec(), expVec());
            end
            checks++;
            if (!$onehot0(floor_sensors) || !$onehot0(floor_level) || int'(car_floor) >= NF) begin
                failures++;
                $display("[TB] FAIL random_invariant%0d: got sens=%b level=%b floor=%0d expected onehot0/onehot0/<%0d",
                         i, floor_sensors, floor_level, car_floor, NF);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        dir     = 1'b0;
        move    = 1'b0;
        test_reset();
        test_continuous_up();
        test_stop_at_floor();
        test_stall();
        test_over_travel();
        test_reversal_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
